axis_ascon_aead128_scoreboard: RTL and testbench

Synthesizable, parametrised loopback scoreboard for an encrypt→decrypt Ascon-AEAD128 chain, for in-system self-test. It taps the plaintext entering the encryptor, sits inline on the ciphertext link from encryptor to decryptor, and checks the decryptor's plaintext and tag outputs. Unlike a formal-only harness, it can inject bit errors into the ciphertext on a chosen beat of a chosen message. It then requires the decryptor to flag that message with a nonzero tag result, and counts passing and failing messages.

---
 rtl/ascon_scoreboard_pkg.sv | 21 ++
 rtl/axis_sync_fifo.sv | 45 ++++
 rtl/axis_ascon_aead128_scoreboard.sv | 187 ++++++++++++++++++
 tb/tb_axis_ascon_aead128_scoreboard.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_scoreboard_pkg.sv
// ascon_scoreboard_pkg
// Shared types and helpers for the Ascon-AEAD128 loopback scoreboard:
//   ij_state_t  - injection FSM states
//   ck_state_t  - check FSM states
//   keep2mask() - expands a byte-keep vector into a per-bit mask
package ascon_scoreboard_pkg;

   typedef enum logic [1:0] {IJ_IDLE, IJ_ARMED, IJ_ACTIVE} ij_state_t;
   typedef enum logic       {CK_DATA, CK_TAG}              ck_state_t;

   // Widest keep vector supported; callers cast to/from their own width.
   localparam int MAX_KW = 64;

   function automatic logic [MAX_KW*8-1:0] keep2mask(input logic [MAX_KW-1:0] keep);
      logic [MAX_KW*8-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_KW; i++) m[i*8 +: 8] = {8{keep[i]}};
      return m;
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo
// Single-clock valid/ready FIFO with first-word fall-through.
//   clk, rst               clock, asynchronous active-high reset (pointers only)
//   s_valid/s_ready/s_data write side; s_ready = not full
//   m_valid/m_ready/m_data read side;  m_valid = not empty, m_data is the head
// Both readies come from pre-edge state, so a pop while full frees no slot
// for a push in the same cycle.
module axis_sync_fifo #(
   parameter int aw = 4,
   parameter int dw = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [dw-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [dw-1:0] m_data
);

   logic [dw-1:0] mem [2**aw];
   logic [aw:0]   wr_ptr, rd_ptr;
   logic          push, pop;

   // Extra pointer bit distinguishes full from empty.
   assign m_valid = wr_ptr != rd_ptr;
   assign s_ready = !((wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]));
   assign m_data  = mem[rd_ptr[aw-1:0]];
   assign push    = s_valid && s_ready;
   assign pop     = m_ready && m_valid;

   always_ff @(posedge clk)
      if (push) mem[wr_ptr[aw-1:0]] <= s_data;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

endmodule

// File: rtl/axis_ascon_aead128_scoreboard.sv
// axis_ascon_aead128_scoreboard
// Loopback self-test scoreboard for an Ascon-AEAD128 encrypt->decrypt chain.
//   s_ref_*   tap of encryptor plaintext, buffered in the reference FIFO
//   s_lnk_* / m_lnk_*  inline ciphertext link, zero latency, optional XOR fault
//   s_chk_*   decryptor plaintext, compared beat-by-beat against the reference
//   s_tag_*   decryptor tag result (0 = authentic), one per message
//   inj_*     arm one bit-error injection on a chosen beat of the next message
//   err_clr   clears data_err / desync
//   msg_pass_cnt/msg_fail_cnt saturating message counters
//   data_err, desync sticky error flags; inj_busy injection armed or in flight
module axis_ascon_aead128_scoreboard
   import ascon_scoreboard_pkg::*;
#(
   parameter int dw      = 128,
   parameter int kw      = dw/8,
   parameter int fifo_aw = 4,
   parameter int msg_aw  = 2,
   parameter int cnt_w   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_ref_tvalid,
   output logic             s_ref_tready,
   input  logic             s_ref_tlast,
   input  logic [dw-1:0]    s_ref_tdata,
   input  logic [kw-1:0]    s_ref_tkeep,
   input  logic             s_lnk_tvalid,
   output logic             s_lnk_tready,
   input  logic             s_lnk_tlast,
   input  logic [dw-1:0]    s_lnk_tdata,
   input  logic [kw-1:0]    s_lnk_tkeep,
   output logic             m_lnk_tvalid,
   input  logic             m_lnk_tready,
   output logic             m_lnk_tlast,
   output logic [dw-1:0]    m_lnk_tdata,
   output logic [kw-1:0]    m_lnk_tkeep,
   input  logic             s_chk_tvalid,
   output logic             s_chk_tready,
   input  logic             s_chk_tlast,
   input  logic [dw-1:0]    s_chk_tdata,
   input  logic [kw-1:0]    s_chk_tkeep,
   input  logic             s_tag_tvalid,
   output logic             s_tag_tready,
   input  logic [127:0]     s_tag_tdata,
   input  logic             inj_arm,
   input  logic [15:0]      inj_beat,
   input  logic [dw-1:0]    inj_mask,
   input  logic             err_clr,
   output logic [cnt_w-1:0] msg_pass_cnt,
   output logic [cnt_w-1:0] msg_fail_cnt,
   output logic             data_err,
   output logic             desync,
   output logic             inj_busy
);

   localparam int rw = 1 + dw + kw;

   logic [dw-1:0] ref_mask, chk_mask;
   logic [rw-1:0] ref_q;
   logic          ref_valid, flag_ready, flag_valid, flag_q, flag_d;
   logic          lnk_hs, chk_hs, tag_hs, flag_push;
   logic          in_msg, hit, hit_seen, msg_bad;
   logic          last_mis, beat_mis, tag_pass, derr_set;
   logic [15:0]   beat_cnt, inj_beat_q;
   logic [dw-1:0] inj_mask_q;
   ij_state_t     ij_state, ij_next;
   ck_state_t     ck_state, ck_next;

   // ---------------- reference FIFO ----------------
   assign ref_mask = dw'(keep2mask(MAX_KW'(s_ref_tkeep)));

   axis_sync_fifo #(.aw(fifo_aw), .dw(rw)) u_ref_fifo (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_ref_tvalid),
      .s_ready (s_ref_tready),
      .s_data  ({s_ref_tlast, s_ref_tdata & ref_mask, s_ref_tkeep}),
      .m_valid (ref_valid),
      .m_ready (chk_hs),
      .m_data  (ref_q)
   );

   // ---------------- link path + injection ----------------
   assign m_lnk_tvalid = s_lnk_tvalid && flag_ready;
   assign s_lnk_tready = m_lnk_tready && flag_ready;
   assign lnk_hs       = s_lnk_tvalid && s_lnk_tready;
   assign m_lnk_tlast  = s_lnk_tlast;
   assign m_lnk_tkeep  = s_lnk_tkeep;

   // The current link message is the injected one either while ACTIVE, or
   // while ARMED on its opening beat (so beat 0 is injectable too).
   assign in_msg      = (ij_state == IJ_ACTIVE) || (ij_state == IJ_ARMED && beat_cnt == '0);
   assign hit         = in_msg && (beat_cnt == inj_beat_q);
   assign m_lnk_tdata = s_lnk_tdata ^ (hit ? inj_mask_q : '0);
   assign flag_push   = lnk_hs && s_lnk_tlast;
   assign flag_d      = in_msg && (hit_seen || (hit && |inj_mask_q));
   assign inj_busy    = ij_state != IJ_IDLE;

   axis_sync_fifo #(.aw(msg_aw), .dw(1)) u_flag_fifo (
      .clk     (clk),
      .rst     (rst),
      .s_valid (flag_push),
      .s_ready (flag_ready),
      .s_data  (flag_d),
      .m_valid (flag_valid),
      .m_ready (tag_hs),
      .m_data  (flag_q)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) ij_state <= IJ_IDLE;
      else     ij_state <= ij_next;

   always_comb begin
      ij_next = ij_state;
      unique case (ij_state)
         IJ_IDLE:   if (inj_arm) ij_next = IJ_ARMED;
         IJ_ARMED:  if (lnk_hs && beat_cnt == '0) ij_next = s_lnk_tlast ? IJ_IDLE : IJ_ACTIVE;
         IJ_ACTIVE: if (lnk_hs && s_lnk_tlast) ij_next = IJ_IDLE;
         default:   ij_next = IJ_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         beat_cnt   <= '0;
         inj_beat_q <= '0;
         inj_mask_q <= '0;
         hit_seen   <= 1'b0;
      end else begin
         if (ij_state == IJ_IDLE && inj_arm) begin
            inj_beat_q <= inj_beat;
            inj_mask_q <= inj_mask;
         end
         if (lnk_hs) beat_cnt <= s_lnk_tlast ? '0 : beat_cnt + 16'd1;
         if (lnk_hs && s_lnk_tlast)              hit_seen <= 1'b0;
         else if (lnk_hs && hit && |inj_mask_q)  hit_seen <= 1'b1;
      end

   // ---------------- check path ----------------
   assign chk_mask     = dw'(keep2mask(MAX_KW'(s_chk_tkeep)));
   assign s_chk_tready = (ck_state == CK_DATA) && ref_valid && flag_valid;
   assign chk_hs       = s_chk_tvalid && s_chk_tready;
   assign s_tag_tready = ck_state == CK_TAG;
   assign tag_hs       = s_tag_tvalid && s_tag_tready;

   assign last_mis = chk_hs && (s_chk_tlast != ref_q[rw-1]);
   assign beat_mis = chk_hs && (((s_chk_tdata & chk_mask) != ref_q[kw +: dw]) ||
                                (s_chk_tkeep != ref_q[kw-1:0]) || last_mis);
   // An injected message must fail authentication; a clean one must pass
   // with matching data.
   assign tag_pass = flag_q ? |s_tag_tdata : (~|s_tag_tdata && !msg_bad);
   assign derr_set = tag_hs && !flag_q && msg_bad;

   always_ff @(posedge clk or posedge rst)
      if (rst) ck_state <= CK_DATA;
      else     ck_state <= ck_next;

   always_comb begin
      ck_next = ck_state;
      unique case (ck_state)
         CK_DATA: if (chk_hs && s_chk_tlast) ck_next = CK_TAG;
         CK_TAG:  if (tag_hs) ck_next = CK_DATA;
         default: ck_next = CK_DATA;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         msg_bad      <= 1'b0;
         msg_pass_cnt <= '0;
         msg_fail_cnt <= '0;
         data_err     <= 1'b0;
         desync       <= 1'b0;
      end else begin
         if (tag_hs)        msg_bad <= 1'b0;
         else if (beat_mis) msg_bad <= 1'b1;
         if (tag_hs && tag_pass && msg_pass_cnt != '1)  msg_pass_cnt <= msg_pass_cnt + 1'b1;
         if (tag_hs && !tag_pass && msg_fail_cnt != '1) msg_fail_cnt <= msg_fail_cnt + 1'b1;
         // set beats clear when both land in the same cycle
         if (derr_set)     data_err <= 1'b1;
         else if (err_clr) data_err <= 1'b0;
         if (last_mis)     desync <= 1'b1;
         else if (err_clr) desync <= 1'b0;
      end

endmodule

// File: tb/tb_axis_ascon_aead128_scoreboard.sv
// tb_axis_ascon_aead128_scoreboard
// Scoreboard bench: stimulus tasks push expected link beats and expected
// per-message outcomes into queues; independent monitors pop and compare
// whenever the DUT handshakes a link beat or a tag.
module tb_axis_ascon_aead128_scoreboard;

   logic         clk = 0, rst = 1;
   logic         s_ref_tvalid = 0, s_ref_tready, s_ref_tlast = 0;
   logic [127:0] s_ref_tdata = 0;
   logic [15:0]  s_ref_tkeep = 0;
   logic         s_lnk_tvalid = 0, s_lnk_tready, s_lnk_tlast = 0;
   logic [127:0] s_lnk_tdata = 0;
   logic [15:0]  s_lnk_tkeep = 0;
   logic         m_lnk_tvalid, m_lnk_tready = 1, m_lnk_tlast;
   logic [127:0] m_lnk_tdata;
   logic [15:0]  m_lnk_tkeep;
   logic         s_chk_tvalid = 0, s_chk_tready, s_chk_tlast = 0;
   logic [127:0] s_chk_tdata = 0;
   logic [15:0]  s_chk_tkeep = 0;
   logic         s_tag_tvalid = 0, s_tag_tready;
   logic [127:0] s_tag_tdata = 0;
   logic         inj_arm = 0;
   logic [15:0]  inj_beat = 0;
   logic [127:0] inj_mask = 0;
   logic         err_clr = 0;
   logic [31:0]  msg_pass_cnt, msg_fail_cnt;
   logic         data_err, desync, inj_busy;

   axis_ascon_aead128_scoreboard dut (
      .clk(clk), .rst(rst),
      .s_ref_tvalid(s_ref_tvalid), .s_ref_tready(s_ref_tready), .s_ref_tlast(s_ref_tlast),
      .s_ref_tdata(s_ref_tdata), .s_ref_tkeep(s_ref_tkeep),
      .s_lnk_tvalid(s_lnk_tvalid), .s_lnk_tready(s_lnk_tready), .s_lnk_tlast(s_lnk_tlast),
      .s_lnk_tdata(s_lnk_tdata), .s_lnk_tkeep(s_lnk_tkeep),
      .m_lnk_tvalid(m_lnk_tvalid), .m_lnk_tready(m_lnk_tready), .m_lnk_tlast(m_lnk_tlast),
      .m_lnk_tdata(m_lnk_tdata), .m_lnk_tkeep(m_lnk_tkeep),
      .s_chk_tvalid(s_chk_tvalid), .s_chk_tready(s_chk_tready), .s_chk_tlast(s_chk_tlast),
      .s_chk_tdata(s_chk_tdata), .s_chk_tkeep(s_chk_tkeep),
      .s_tag_tvalid(s_tag_tvalid), .s_tag_tready(s_tag_tready), .s_tag_tdata(s_tag_tdata),
      .inj_arm(inj_arm), .inj_beat(inj_beat), .inj_mask(inj_mask), .err_clr(err_clr),
      .msg_pass_cnt(msg_pass_cnt), .msg_fail_cnt(msg_fail_cnt),
      .data_err(data_err), .desync(desync), .inj_busy(inj_busy)
   );

   always #5 clk = ~clk;

   typedef struct { int p; int f; bit de; bit ds; } res_t;
   res_t         res_q[$];
   logic [127:0] lnk_q[$];
   int checks = 0, errors = 0;
   int m_pass = 0, m_fail = 0;
   bit m_derr = 0, m_desync = 0;

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] kmask(input logic [15:0] k);
      logic [127:0] m;
      for (int i = 0; i < 16; i++) m[i*8 +: 8] = {8{k[i]}};
      return m;
   endfunction

   task automatic chk_eq(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // wait (bounded) for the selected ready, then finish the handshake edge
   task automatic hs(input string nm, input int sel);
      int n;
      bit r;
      n = 0;
      forever begin
         @(negedge clk);
         case (sel)
            0: r = s_ref_tready;
            1: r = s_lnk_tready;
            2: r = s_chk_tready;
            default: r = s_tag_tready;
         endcase
         if (r) break;
         if (++n > 200) begin
            checks++; errors++;
            $display("FAIL timeout_%s: ready stayed low 200 cycles, required high", nm);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic send_ref(input logic [127:0] d, input logic [15:0] k, input bit l);
      s_ref_tvalid = 1; s_ref_tdata = d; s_ref_tkeep = k; s_ref_tlast = l;
      hs("ref", 0);
      s_ref_tvalid = 0;
   endtask

   task automatic send_lnk(input logic [127:0] d, input logic [15:0] k, input bit l);
      s_lnk_tvalid = 1; s_lnk_tdata = d; s_lnk_tkeep = k; s_lnk_tlast = l;
      hs("lnk", 1);
      s_lnk_tvalid = 0;
   endtask

   task automatic send_chk(input logic [127:0] d, input logic [15:0] k, input bit l);
      s_chk_tvalid = 1; s_chk_tdata = d; s_chk_tkeep = k; s_chk_tlast = l;
      hs("chk", 2);
      s_chk_tvalid = 0;
   endtask

   task automatic send_tag(input logic [127:0] t);
      s_tag_tvalid = 1; s_tag_tdata = t;
      hs("tag", 3);
      s_tag_tvalid = 0;
   endtask

   task automatic arm(input int b, input logic [127:0] m);
      inj_arm = 1; inj_beat = 16'(b); inj_mask = m;
      @(posedge clk); #1;
      inj_arm = 0;
   endtask

   task automatic reset_dut();
      s_ref_tvalid = 0; s_lnk_tvalid = 0; s_chk_tvalid = 0; s_tag_tvalid = 0;
      inj_arm = 0; err_clr = 0; m_lnk_tready = 1;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      m_pass = 0; m_fail = 0; m_derr = 0; m_desync = 0;
      res_q.delete(); lnk_q.delete();
   endtask

   // One full message through ref, link, check and tag; the expected outcome
   // follows directly from the pass/fail rules.
   task automatic run_msg(input int len, input logic [15:0] lkeep, input bit inj, input int ibeat,
                          input logic [127:0] imask, input bit fault, input bit early,
                          input logic [127:0] tag);
      logic [127:0] pt[4];
      logic [15:0]  kp[4];
      bit flag, bad, pass;
      res_t r;
      if (inj) begin
         arm(ibeat, imask);
         chk_eq("inj_busy_armed", inj_busy, 1);
      end
      flag = inj && ibeat < len && imask != 0;
      bad  = fault || early;
      pass = flag ? (tag != 0) : (tag == 0 && !bad);
      if (pass) m_pass++; else m_fail++;
      if (!flag && bad) m_derr = 1;
      if (early) m_desync = 1;
      r.p = m_pass; r.f = m_fail; r.de = m_derr; r.ds = m_desync;
      res_q.push_back(r);
      for (int b = 0; b < len; b++) begin
         pt[b] = rnd128();
         kp[b] = (b == len-1) ? lkeep : 16'hFFFF;
         send_ref(pt[b], kp[b], b == len-1);
      end
      for (int b = 0; b < len; b++) begin
         logic [127:0] ct;
         ct = rnd128();
         lnk_q.push_back(ct ^ ((inj && b == ibeat) ? imask : 128'd0));
         send_lnk(ct, kp[b], b == len-1);
      end
      chk_eq("inj_busy_after_tlast", inj_busy, 0);
      for (int b = 0; b < len; b++) begin
         logic [127:0] d;
         d = (pt[b] & kmask(kp[b])) | (rnd128() & ~kmask(kp[b]));
         if (fault && b == 0) d[0] = ~d[0];
         if (inj && b == ibeat) d = d ^ imask;
         send_chk(d, kp[b], early ? 1'b1 : (b == len-1));
         if (early) break;
      end
      send_tag(tag);
      repeat (2) @(posedge clk); #1;
   endtask

   // link monitor
   initial forever begin
      @(negedge clk);
      if (!rst && m_lnk_tvalid && m_lnk_tready) begin
         if (lnk_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL lnk_unexpected: got beat %0h, required none", m_lnk_tdata);
         end else chk_eq("m_lnk_tdata", m_lnk_tdata, lnk_q.pop_front());
      end
   end

   // tag/outcome monitor: counters and sticky flags one edge after the tag handshake
   initial forever begin
      @(negedge clk);
      if (!rst && s_tag_tvalid && s_tag_tready) begin
         @(negedge clk);
         if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tag_unexpected: got tag handshake, required none");
         end else begin
            res_t r;
            r = res_q.pop_front();
            chk_eq("msg_pass_cnt", msg_pass_cnt, r.p);
            chk_eq("msg_fail_cnt", msg_fail_cnt, r.f);
            chk_eq("data_err", data_err, r.de);
            chk_eq("desync", desync, r.ds);
         end
      end
   end

   initial begin
      logic [127:0] bp_pt[10];
      reset_dut();
      @(negedge clk);
      chk_eq("rst_ref_tready", s_ref_tready, 1);
      chk_eq("rst_chk_tready", s_chk_tready, 0);
      chk_eq("rst_tag_tready", s_tag_tready, 0);
      chk_eq("rst_pass", msg_pass_cnt, 0);
      chk_eq("rst_flags", {data_err, desync, inj_busy}, 0);
      @(posedge clk); #1;

      // clean, effective injection, injection beyond length, decoder fault
      run_msg(3, 16'hFFF0, 0, 0, 0, 0, 0, 0);
      run_msg(3, 16'hFFFF, 1, 1, 128'd1 << 5, 0, 0, 128'h1234);
      run_msg(2, 16'hFFFF, 1, 7, 128'd1 << 9, 0, 0, 0);
      run_msg(3, 16'hFFFF, 0, 0, 0, 1, 0, 0);
      err_clr = 1;
      @(posedge clk); #1;
      err_clr = 0;
      m_derr = 0;
      @(negedge clk);
      chk_eq("data_err_after_clr", data_err, m_derr);
      @(posedge clk); #1;
      // injection on a single-beat tlast message
      run_msg(1, 16'h00FF, 1, 0, 128'h80, 0, 0, 128'h1);

      // randomized messages
      for (int i = 0; i < 16; i++) begin
         int len, ib;
         bit inj, flt, fl;
         logic [127:0] msk, tg;
         len = $urandom_range(1, 4);
         inj = 1'($urandom_range(0, 1));
         ib  = $urandom_range(0, 5);
         msk = ($urandom_range(0, 3) == 0) ? 128'd0 : (128'd1 << $urandom_range(0, 127));
         flt = (len >= 2) && ($urandom_range(0, 3) == 0);
         fl  = inj && ib < len && msk != 0;
         if (fl) tg = ($urandom_range(0, 3) == 0) ? 128'd0 : (rnd128() | 128'd1);
         else    tg = ($urandom_range(0, 4) == 0) ? (rnd128() | 128'd1) : 128'd0;
         run_msg(len, 16'($urandom_range(1, 65535)), inj, ib, msk, flt, 0, tg);
      end

      // desync: check stream ends a 2-beat message after beat 0
      run_msg(2, 16'hFFFF, 0, 0, 0, 0, 1, 0);
      reset_dut();
      @(negedge clk);
      chk_eq("desync_after_rst", desync, 0);
      @(posedge clk); #1;

      // backpressure: link stalled, then 4 messages fill the flag FIFO
      for (int m = 0; m < 5; m++)
         for (int b = 0; b < 2; b++) begin
            bp_pt[2*m+b] = rnd128();
            send_ref(bp_pt[2*m+b], 16'hFFFF, b == 1);
         end
      m_lnk_tready = 0;
      s_lnk_tvalid = 1; s_lnk_tdata = rnd128(); s_lnk_tlast = 0; s_lnk_tkeep = 16'hFFFF;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk_eq("stall_s_lnk_tready", s_lnk_tready, 0);
      chk_eq("stall_m_lnk_tvalid", m_lnk_tvalid, 1);
      @(posedge clk); #1;
      s_lnk_tvalid = 0;
      m_lnk_tready = 1;
      for (int m = 0; m < 4; m++)
         for (int b = 0; b < 2; b++) begin
            logic [127:0] ct;
            ct = rnd128();
            lnk_q.push_back(ct);
            send_lnk(ct, 16'hFFFF, b == 1);
         end
      s_lnk_tvalid = 1; s_lnk_tdata = rnd128(); s_lnk_tlast = 0;
      @(negedge clk);
      chk_eq("flag_full_m_lnk_tvalid", m_lnk_tvalid, 0);
      chk_eq("flag_full_s_lnk_tready", s_lnk_tready, 0);
      chk_eq("chk_ready_with_data", s_chk_tready, 1);
      @(posedge clk); #1;
      send_chk(bp_pt[0], 16'hFFFF, 0);
      arm(1, 128'hF);
      chk_eq("bp_inj_busy", inj_busy, 1);
      // reset mid-message
      rst = 1;
      @(negedge clk);
      chk_eq("mid_rst_ref_tready", s_ref_tready, 1);
      chk_eq("mid_rst_chk_tready", s_chk_tready, 0);
      chk_eq("mid_rst_tag_tready", s_tag_tready, 0);
      chk_eq("mid_rst_counters", {msg_pass_cnt, msg_fail_cnt}, 0);
      chk_eq("mid_rst_flags", {data_err, desync, inj_busy}, 0);
      chk_eq("mid_rst_m_lnk_tvalid", m_lnk_tvalid, 1);
      chk_eq("mid_rst_m_lnk_tdata", m_lnk_tdata, s_lnk_tdata);
      @(posedge clk); #1;
      s_lnk_tvalid = 0;
      reset_dut();
      @(negedge clk);
      chk_eq("post_rst_chk_tready", s_chk_tready, 0);
      chk_eq("post_rst_inj_busy", inj_busy, 0);
      chk_eq("lnk_q_drained", 32'(lnk_q.size()), 0);
      chk_eq("res_q_drained", 32'(res_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
